// File: rtl/riscv_imm_pkg.sv
// Shared constants and types for the immediate encoder: format codes, the two
// opcodes used by li expansion, and the FSM state type.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } state_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RISC-V format packer: scatters the immediate into its format
// slots and flags immediates the format cannot represent.
module imm_pack
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (imm_src)
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = imm[0] || (imm[31:12] != {20{imm[12]}});
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = imm[0] || (imm[31:20] != {12{imm[20]}});
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      default: begin
        // Reserved format codes: emit a zero word so nothing half-valid escapes.
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with li expansion: packs one instruction per request, or a
// LUI/ADDI pair for li, onto a valid/ready output stream.
module imm_encoder
  import riscv_imm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [2:0]  req_immSrc,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] addi_q, addi_d;

  logic        fits12;
  logic [19:0] hi;
  logic        two_beat;
  logic        accept;

  logic [2:0]  p_src;
  logic [6:0]  p_opcode;
  logic [2:0]  p_funct3;
  logic [4:0]  p_rs1;
  logic [4:0]  p_rs2;
  logic [31:0] p_imm;
  logic [31:0] p_instr;
  logic        p_err;
  logic [31:0] addi_instr;
  logic        addi_err_unused;
  logic        unused_bits;

  assign fits12   = (req_imm[31:11] == {21{req_imm[11]}});
  // Rounding up by imm[11] compensates for the ADDI sign-extending its low 12 bits.
  assign hi       = req_imm[31:12] + {19'd0, req_imm[11]};
  assign two_beat = req_li && !fits12 && (req_imm[11:0] != 12'd0);

  assign p_src    = req_li ? (fits12 ? IMM_I : IMM_U) : req_immSrc;
  assign p_opcode = req_li ? (fits12 ? OP_OPIMM : OP_LUI) : req_opcode;
  assign p_funct3 = req_li ? 3'd0 : req_funct3;
  assign p_rs1    = req_li ? 5'd0 : req_rs1;
  assign p_rs2    = req_li ? 5'd0 : req_rs2;
  assign p_imm    = req_li ? (fits12 ? req_imm : {hi, 12'd0}) : req_imm;

  imm_pack u_req_pack (
    .imm_src (p_src),
    .opcode  (p_opcode),
    .funct3  (p_funct3),
    .rd      (req_rd),
    .rs1     (p_rs1),
    .rs2     (p_rs2),
    .imm     (p_imm),
    .instr   (p_instr),
    .err     (p_err)
  );

  imm_pack u_addi_pack (
    .imm_src (IMM_I),
    .opcode  (OP_OPIMM),
    .funct3  (3'd0),
    .rd      (req_rd),
    .rs1     (req_rd),
    .rs2     (5'd0),
    .imm     (sext12(req_imm[11:0])),
    .instr   (addi_instr),
    .err     (addi_err_unused)
  );

  assign unused_bits = ^{req_funct7, addi_err_unused};

  assign req_ready = !reset && (state_q == ST_IDLE) && (!valid_q || out_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    addi_d  = addi_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          instr_d = p_instr;
          last_d  = !two_beat;
          err_d   = req_li ? 1'b0 : p_err;
          if (two_beat) begin
            state_d = ST_SECOND;
            addi_d  = addi_instr;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      ST_SECOND: begin
        if (out_ready) begin
          valid_d = 1'b1;
          instr_d = addi_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      addi_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      addi_q  <= addi_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected beats are queued at drive time and
// checked as the output handshake completes; random beats are decoded back.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_li;
  logic [2:0]  req_immSrc;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_last, out_err;

  typedef struct {
    logic        rt;
    logic [31:0] instr;
    logic        last;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  opc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  imm_encoder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_li(req_li),
    .req_immSrc(req_immSrc), .req_opcode(req_opcode), .req_funct3(req_funct3),
    .req_funct7(req_funct7), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
  );

  function automatic logic [31:0] decode_imm(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'd0};
    endcase
  endfunction

  // Output monitor: a beat transfers at the next posedge iff valid&&ready now.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got instr=%08h last=%0b err=%0b, required no beat",
                 out_instr, out_last, out_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rt) begin
          if (decode_imm(out_instr, e.src) !== e.imm || out_err !== 1'b0 ||
              out_last !== 1'b1 || out_instr[6:0] !== e.opc) begin
            errors++;
            $display("FAIL roundtrip src=%0d: got instr=%08h decoded=%08h err=%0b last=%0b, required imm=%08h opc=%02h err=0 last=1",
                     e.src, out_instr, decode_imm(out_instr, e.src), out_err, out_last, e.imm, e.opc);
          end
        end else if (out_instr !== e.instr || out_last !== e.last || out_err !== e.err) begin
          errors++;
          $display("FAIL beat: got instr=%08h last=%0b err=%0b, required instr=%08h last=%0b err=%0b",
                   out_instr, out_last, out_err, e.instr, e.last, e.err);
        end
      end
    end
  end

  task automatic push_exact(input logic [31:0] instr, input logic last, input logic err);
    exp_t e;
    e = '{rt: 1'b0, instr: instr, last: last, err: err, src: 3'd0, imm: 32'd0, opc: 7'd0};
    sb.push_back(e);
  endtask

  task automatic push_rt(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] opc);
    exp_t e;
    e = '{rt: 1'b1, instr: 32'd0, last: 1'b1, err: 1'b0, src: src, imm: imm, opc: opc};
    sb.push_back(e);
  endtask

  // Present one request and hold it until accepted; returns at posedge+1.
  task automatic send(input logic li, input logic [2:0] src, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit ok = 0;
    req_li = li; req_immSrc = src; req_opcode = opc; req_funct3 = f3;
    req_funct7 = 7'h7F; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1 within 50 cycles", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1; req_li = 1'b0;
    req_immSrc = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    #1;
    checks++;
    if ({out_valid, out_instr, out_last, out_err, req_ready} !== 36'd0) begin
      errors++;
      $display("FAIL reset_values: valid=%0b instr=%08h last=%0b err=%0b req_ready=%0b, required all 0",
               out_valid, out_instr, out_last, out_err, req_ready);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, required 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    int t0;
    push_exact(32'hFFF00293, 1'b1, 1'b0);
    send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    t0 = cycle;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || cycle != t0) begin
      errors++;
      $display("FAIL latency: out_valid=%0b after %0d cycles, required 1 after 1", out_valid, cycle - t0 + 1);
    end
    drain();
  endtask

  task automatic test_li();
    push_exact(32'h123460B7, 1'b0, 1'b0);
    push_exact(32'hFFF08093, 1'b1, 1'b0);
    send(1'b1, 3'd7, 7'h7F, 3'd7, 5'd1, 5'd31, 5'd31, 32'h12345FFF);
    push_exact(32'h00001137, 1'b1, 1'b0);
    send(1'b1, 3'd7, 7'h7F, 3'd7, 5'd2, 5'd31, 5'd31, 32'h00001000);
    push_exact(32'hFFB00193, 1'b1, 1'b0);
    send(1'b1, 3'd7, 7'h7F, 3'd7, 5'd3, 5'd31, 5'd31, 32'hFFFFFFFB);
    // hi rounds up: 0x7FFFF800 needs LUI 0x80000 then ADDI -2048
    push_exact(32'h800002B7, 1'b0, 1'b0);
    push_exact(32'h80028293, 1'b1, 1'b0);
    send(1'b1, 3'd0, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h7FFFF800);
    drain();
  endtask

  task automatic test_range_err();
    push_exact(32'h8020A023, 1'b1, 1'b1);
    send(1'b0, 3'd1, 7'b0100011, 3'd2, 5'd0, 5'd1, 5'd2, 32'd2048);
    push_exact(32'h002080E3, 1'b1, 1'b1);
    send(1'b0, 3'd2, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000801);
    push_exact(32'h000002B7, 1'b1, 1'b1);
    send(1'b0, 3'd4, 7'b0110111, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00000123);
    push_exact(32'h00000000, 1'b1, 1'b1);
    send(1'b0, 3'd5, 7'b0010011, 3'd1, 5'd5, 5'd6, 5'd7, 32'h00000004);
    push_exact(32'h80000093, 1'b1, 1'b1);
    send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    // Representable extremes stay error-free
    push_rt(3'd0, 32'd2047, 7'b0010011);
    send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
    push_rt(3'd2, 32'hFFFFF000, 7'b1100011);
    send(1'b0, 3'd2, 7'b1100011, 3'd1, 5'd0, 5'd3, 5'd4, 32'hFFFFF000);
    push_rt(3'd3, 32'h000FFFFE, 7'b1101111);
    send(1'b0, 3'd3, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000FFFFE);
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cycle;
    for (int n = 0; n < 8; n++) begin
      push_rt(3'd0, 32'(n) - 32'd4, 7'b0010011);
      send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'(n), 5'd1, 5'd0, 32'(n) - 32'd4);
    end
    checks++;
    if (cycle - t0 != 8) begin
      errors++;
      $display("FAIL throughput: 8 requests took %0d cycles, required 8", cycle - t0);
    end
    t0 = cycle;
    push_exact(32'h123460B7, 1'b0, 1'b0);
    push_exact(32'hFFF08093, 1'b1, 1'b0);
    send(1'b1, 3'd0, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
    push_rt(3'd0, 32'd7, 7'b0010011);
    send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'd9, 5'd1, 5'd0, 32'd7);
    checks++;
    if (cycle - t0 != 3) begin
      errors++;
      $display("FAIL li_occupancy: li plus next request took %0d cycles, required 3", cycle - t0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    out_ready = 1'b0;
    push_exact(32'h123460B7, 1'b0, 1'b0);
    push_exact(32'hFFF08093, 1'b1, 1'b0);
    send(1'b1, 3'd0, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h123460B7 || out_last !== 1'b0 ||
          out_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c=%0d: valid=%0b instr=%08h last=%0b err=%0b req_ready=%0b, required 1/123460B7/0/0/0",
                 c, out_valid, out_instr, out_last, out_err, req_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    seen = (req_ready === 1'b1);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ready_after_stall: req_ready=%0b, required 1", req_ready);
    end
  endtask

  task automatic test_reset_second();
    out_ready = 1'b0;
    push_exact(32'h123460B7, 1'b0, 1'b0);
    send(1'b1, 3'd0, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b instr=%08h last=%0b, required 0/00000000/0",
               out_valid, out_instr, out_last);
    end
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exact(32'hFFF00293, 1'b1, 1'b0);
    send(1'b0, 3'd0, 7'b0010011, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_roundtrip();
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] r, imm;
      logic [2:0]  src;
      logic [6:0]  opc;
      r   = $urandom;
      src = 3'($urandom_range(0, 4));
      opc = 7'($urandom);
      case (src)
        3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
        3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
        default:    imm = {r[31:12], 12'd0};
      endcase
      push_rt(src, imm, opc);
      send(1'b0, src, opc, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_itype();
    test_li();
    test_range_err();
    test_back_to_back();
    test_backpressure();
    test_reset_second();
    test_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
